// File: rtl/y_median3x3_filter.sv
// Streaming 3x3 median on the luma plane. Two line buffers feed a five-stage
// compare/select pipeline; border pixels bypass the median and syncs are delayed to match.
module y_median3x3_filter #(
   parameter int IMG_WIDTH = 640,
   parameter int COL_W     = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pre_frame_vsync,
   input  logic       pre_frame_hsync,
   input  logic       pre_frame_de,
   input  logic [7:0] img_y_in,
   output logic       post_frame_vsync,
   output logic       post_frame_hsync,
   output logic       post_frame_de,
   output logic [7:0] img_y_out
);

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

   function automatic logic [7:0] f_min2(input logic [7:0] a, input logic [7:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [7:0] f_max2(input logic [7:0] a, input logic [7:0] b);
      return (a < b) ? b : a;
   endfunction

   function automatic logic [7:0] f_med3(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
      return f_max2(f_min2(a, b), f_min2(f_max2(a, b), c));
   endfunction

   // Returns {max, med, min}.
   function automatic logic [23:0] f_sort3(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
      logic [7:0] lo;
      logic [7:0] hi;
      lo = f_min2(a, b);
      hi = f_max2(a, b);
      return {f_max2(hi, c), f_max2(lo, f_min2(hi, c)), f_min2(lo, c)};
   endfunction

   logic                 r_vs_d;
   logic                 r_de_d;
   logic                 r_over;
   logic [COL_W-1:0]     r_col;
   logic [1:0]           r_row;
   logic                 w_vs_rise;
   logic                 w_de_fall;
   logic                 w_border;
   logic                 w_lb_we;
   logic [7:0]           w_lb1_q;
   logic [7:0]           w_lb2_q;
   logic [7:0]           r_lb1 [0:IMG_WIDTH-1];
   logic [7:0]           r_lb2 [0:IMG_WIDTH-1];
   logic [4:0]           r_vs_pipe;
   logic [4:0]           r_hs_pipe;
   logic [4:0]           r_de_pipe;
   logic [3:0][7:0]      r_raw_pipe;
   logic [3:0]           r_bdr_pipe;
   logic [2:0][7:0]      r_s1_tup;
   logic [2:0][2:0][7:0] r_win;
   logic [2:0][7:0]      r_s3_min;
   logic [2:0][7:0]      r_s3_med;
   logic [2:0][7:0]      r_s3_max;
   logic [2:0][7:0]      r_s4_val;
   logic [7:0]           w_s5_y;
   logic [7:0]           r_y_out;

   assign w_vs_rise = pre_frame_vsync & ~r_vs_d;
   assign w_de_fall = ~pre_frame_de & r_de_d;
   // r_over marks pixels past the last buffer column; they never touch the RAMs.
   assign w_border  = (r_row < 2'd2) | (r_col < COL_W'(2)) | r_over;
   assign w_lb_we   = pre_frame_de & ~r_over & ~rst;
   assign w_lb1_q   = r_lb1[r_col];
   assign w_lb2_q   = r_lb2[r_col];

   // Column/row position tracking; a vsync rise outranks a same-cycle de fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vs_d <= 1'b0;
         r_de_d <= 1'b0;
         r_row  <= 2'd0;
         r_col  <= '0;
         r_over <= 1'b0;
      end else begin
         r_vs_d <= pre_frame_vsync;
         r_de_d <= pre_frame_de;
         if (w_vs_rise) begin
            r_row <= 2'd0;
         end else if (w_de_fall && (r_row != 2'd2)) begin
            r_row <= r_row + 2'd1;
         end
         if (!pre_frame_de) begin
            r_col  <= '0;
            r_over <= 1'b0;
         end else if (r_col == LAST_COL) begin
            r_over <= 1'b1;
         end else begin
            r_col <= r_col + COL_W'(1);
         end
      end
   end

   // Line buffers: read-before-write, LB1 cascades into LB2.
   always_ff @(posedge clk) begin
      if (w_lb_we) begin
         r_lb1[r_col] <= img_y_in;
         r_lb2[r_col] <= w_lb1_q;
      end
   end

   // S1..S4 pipeline registers plus sync/raw/border delay lines.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vs_pipe  <= 5'd0;
         r_hs_pipe  <= 5'd0;
         r_de_pipe  <= 5'd0;
         r_raw_pipe <= '0;
         r_bdr_pipe <= 4'd0;
         r_s1_tup   <= '0;
         r_win      <= '0;
         r_s3_min   <= '0;
         r_s3_med   <= '0;
         r_s3_max   <= '0;
         r_s4_val   <= '0;
      end else begin
         r_vs_pipe  <= {r_vs_pipe[3:0], pre_frame_vsync};
         r_hs_pipe  <= {r_hs_pipe[3:0], pre_frame_hsync};
         r_de_pipe  <= {r_de_pipe[3:0], pre_frame_de};
         r_raw_pipe <= {r_raw_pipe[2:0], img_y_in};
         r_bdr_pipe <= {r_bdr_pipe[2:0], w_border};
         r_s1_tup   <= {w_lb2_q, w_lb1_q, img_y_in};
         for (int i = 0; i < 3; i++) begin
            if (r_de_pipe[0]) begin
               r_win[i] <= {r_win[i][1:0], r_s1_tup[i]};
            end
            {r_s3_max[i], r_s3_med[i], r_s3_min[i]} <= f_sort3(r_win[i][0], r_win[i][1],
                                                               r_win[i][2]);
         end
         r_s4_val[0] <= f_max2(f_max2(r_s3_min[0], r_s3_min[1]), r_s3_min[2]);
         r_s4_val[1] <= f_med3(r_s3_med[0], r_s3_med[1], r_s3_med[2]);
         r_s4_val[2] <= f_min2(f_min2(r_s3_max[0], r_s3_max[1]), r_s3_max[2]);
      end
   end

   // S5 select: blank, raw border pixel, or final median.
   always_comb begin
      w_s5_y = 8'd0;
      if (!r_de_pipe[3]) begin
         w_s5_y = 8'd0;
      end else if (r_bdr_pipe[3]) begin
         w_s5_y = r_raw_pipe[3];
      end else begin
         w_s5_y = f_med3(r_s4_val[0], r_s4_val[1], r_s4_val[2]);
      end
   end

   // S5 output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_y_out <= 8'd0;
      end else begin
         r_y_out <= w_s5_y;
      end
   end

   assign post_frame_vsync = r_vs_pipe[4];
   assign post_frame_hsync = r_hs_pipe[4];
   assign post_frame_de    = r_de_pipe[4];
   assign img_y_out        = r_y_out;

endmodule

// File: tb/tb_y_median3x3_filter.sv
// Scoreboard bench for y_median3x3_filter: the driver pushes one expected output
// per cycle, the monitor pops and compares 5 clocks later.
module tb_y_median3x3_filter;

   localparam int W = 8;

   typedef struct packed {
      logic       vs;
      logic       hs;
      logic       de;
      logic [7:0] y;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       vs;
   logic       hs;
   logic       de;
   logic [7:0] yin;
   logic       post_vs;
   logic       post_hs;
   logic       post_de;
   logic [7:0] yout;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   y_median3x3_filter #(.IMG_WIDTH(W), .COL_W(3)) dut (
      .clk              (clk),
      .rst              (rst),
      .pre_frame_vsync  (vs),
      .pre_frame_hsync  (hs),
      .pre_frame_de     (de),
      .img_y_in         (yin),
      .post_frame_vsync (post_vs),
      .post_frame_hsync (post_hs),
      .post_frame_de    (post_de),
      .img_y_out        (yout)
   );

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   test_done = 1'b0;

   // Behavioural reference state
   int         m_row;
   int         m_col;
   bit         m_over;
   bit         m_vs_d;
   bit         m_de_d;
   logic [7:0] m_lb1 [W];
   logic [7:0] m_lb2 [W];
   logic [7:0] m_win [3][3];

   function automatic logic [7:0] median9();
      logic [7:0] v [9];
      logic [7:0] t;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) v[i*3+j] = m_win[i][j];
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 8 - i; j++)
            if (v[j] > v[j+1]) begin
               t = v[j]; v[j] = v[j+1]; v[j+1] = t;
            end
      return v[4];
   endfunction

   // One clock of stimulus; pushes the expected output for this input cycle.
   task automatic cyc(input bit r, input bit v, input bit h, input bit d,
                      input logic [7:0] y, input bit use_hand, input logic [7:0] hand);
      exp_t       e;
      bit         bdr;
      logic [7:0] t1;
      logic [7:0] t2;
      @(posedge clk);
      #1;
      rst = r; vs = v; hs = h; de = d; yin = y;
      e = '0;
      if (r) begin
         for (int i = exp_q.size() - 4; i < exp_q.size(); i++)
            if (i >= 0) exp_q[i] = '0;
         m_row = 0; m_col = 0; m_over = 1'b0; m_vs_d = 1'b0; m_de_d = 1'b0;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) m_win[i][j] = 8'd0;
      end else begin
         bdr  = (m_row < 2) || (m_col < 2) || m_over;
         e.vs = v; e.hs = h; e.de = d;
         if (d) begin
            t1 = m_lb1[m_col];
            t2 = m_lb2[m_col];
            if (!m_over) begin
               m_lb2[m_col] = t1;
               m_lb1[m_col] = y;
            end
            for (int i = 0; i < 3; i++) begin
               m_win[i][2] = m_win[i][1];
               m_win[i][1] = m_win[i][0];
            end
            m_win[0][0] = y; m_win[1][0] = t1; m_win[2][0] = t2;
            e.y = use_hand ? hand : (bdr ? y : median9());
         end
         if (v && !m_vs_d) m_row = 0;
         else if (!d && m_de_d && m_row < 2) m_row++;
         if (!d) begin
            m_col = 0; m_over = 1'b0;
         end else if (m_col == W - 1) begin
            m_over = 1'b1;
         end else begin
            m_col++;
         end
         m_vs_d = v; m_de_d = d;
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
   endtask

   task automatic frame_start();
      repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
      idle(2);
   endtask

   // kind: 0 flat, 1 impulse, 2 ramp (hand-computed), 3 random (reference model)
   task automatic line(input int len, input int kind, input int row,
                       input int vs_at, input int rst_at);
      logic [7:0] y;
      logic [7:0] hand;
      bit         uh;
      bit         r;
      bit         v;
      repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
      for (int c = 0; c < len; c++) begin
         uh = 1'b1;
         case (kind)
            0: begin y = 8'd100; hand = 8'd100; end
            1: begin y = (row == 2 && c == 3) ? 8'd255 : 8'd50; hand = 8'd50; end
            2: begin
               y    = 8'(10 * c);
               hand = (row >= 2 && c >= 2) ? 8'(10 * (c - 1)) : 8'(10 * c);
            end
            default: begin y = 8'($urandom_range(0, 255)); hand = 8'd0; uh = 1'b0; end
         endcase
         r = (rst_at >= 0) && (c >= rst_at) && (c < rst_at + 2);
         v = (vs_at >= 0) && (c >= vs_at) && (c < vs_at + 2);
         cyc(r, v, 1'b0, 1'b1, y, uh, hand);
      end
      idle(4);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() >= 6) begin
         mon_e = exp_q.pop_front();
         n_checks++;
         if ({post_vs, post_hs, post_de, yout} !== mon_e) begin
            n_fail++;
            $display("FAIL out_cmp t=%0t got vs=%0b hs=%0b de=%0b y=%0d expected vs=%0b hs=%0b de=%0b y=%0d",
                     $time, post_vs, post_hs, post_de, yout,
                     mon_e.vs, mon_e.hs, mon_e.de, mon_e.y);
         end
      end
   end

   initial begin
      #2000000;
      if (!test_done) begin
         n_fail++;
         $display("FAIL timeout t=%0t: test did not complete in time", $time);
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
         $finish;
      end
   end

   initial begin
      rst = 1'b1; vs = 1'b0; hs = 1'b0; de = 1'b0; yin = 8'd0;
      m_row = 0; m_col = 0; m_over = 1'b0; m_vs_d = 1'b0; m_de_d = 1'b0;
      for (int i = 0; i < W; i++) begin
         m_lb1[i] = 8'd0;
         m_lb2[i] = 8'd0;
      end
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) m_win[i][j] = 8'd0;

      // Reset held with active-looking inputs, then first de after release
      repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 8'd0);
      n_checks++;
      if ({post_vs, post_hs, post_de, yout} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_state t=%0t got vs=%0b hs=%0b de=%0b y=%0d expected all 0",
                  $time, post_vs, post_hs, post_de, yout);
      end
      idle(3);
      line(W, 3, 0, -1, -1);

      frame_start();
      for (int r = 0; r < 4; r++) line(W, 0, r, -1, -1);

      frame_start();
      for (int r = 0; r < 5; r++) line(W, 1, r, -1, -1);

      frame_start();
      for (int r = 0; r < 4; r++) line(W, 2, r, -1, -1);

      // Long line (10 pixels) in row 2
      frame_start();
      for (int r = 0; r < 5; r++) line((r == 2) ? W + 2 : W, 3, r, -1, -1);

      // vsync pulse mid row 3
      frame_start();
      for (int r = 0; r < 7; r++) line(W, 3, r, (r == 3) ? 4 : -1, -1);

      // rst pulse mid row 3
      frame_start();
      for (int r = 0; r < 7; r++) line(W, 3, r, -1, (r == 3) ? 3 : -1);

      idle(10);
      test_done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/y_median3x3_filter.md
# y_median3x3_filter

Streaming 3×3 median filter on the luma plane, placed directly downstream of the RGB565→YCbCr converter in the camera-to-VGA pipeline. It consumes the converter's Y output with its vsync/hsync/de timing and removes impulse noise before binarisation and display. It uses two line buffers and a five-stage compare/select pipeline, and delays the sync signals to match. Cb/Cr are not processed here.

## Interface
- IMG_WIDTH, 640: maximum active pixels per line; sets line-buffer depth.
- COL_W, 10: column-counter width; must satisfy 2^COL_W ≥ IMG_WIDTH.
- clk  input  1  pixel clock.
- rst  input  1  reset; one clock; synchronous, active-high.
- pre_frame_vsync  input  1  frame sync from the converter.
- pre_frame_hsync  input  1  line sync from the converter.
- pre_frame_de  input  1  data enable; img_y_in is valid when high.
- img_y_in  input  8  luma in.
- post_frame_vsync  output  1  pre_frame_vsync delayed 5 clocks.
- post_frame_hsync  output  1  pre_frame_hsync delayed 5 clocks.
- post_frame_de  output  1  pre_frame_de delayed 5 clocks.
- img_y_out  output  8  filtered luma; 0 whenever post_frame_de is low.

## Operation
- **Counters**
  - col_cnt counts de-high pixels in the current line. It clears while de is low and saturates at IMG_WIDTH-1.
  - row_cnt is 2 bits and saturates at 2. It increments on each de falling edge and clears on a vsync rising edge (edge detected on the registered vsync).
- **Line buffers**
  - Two IMG_WIDTH×8 RAMs, LB1 and LB2, addressed by col_cnt. Both are read-before-write in the same cycle.
  - When de is high: LB1[col] ← img_y_in and LB2[col] ← old LB1[col].
  - When de is low, or for pixels with index ≥ IMG_WIDTH: no writes.
  - RAM contents are not cleared by rst.
- **Pipeline** (all registers clear on rst):
  - S1: register the column tuple (row r, r-1, r-2) = (img_y_in, LB1 out, LB2 out), plus de, raw Y and a border flag. border = (row_cnt < 2) or (col_cnt < 2) or (pixel index ≥ IMG_WIDTH).
  - S2: shift the tuple into a 3-column window. The window advances only on de-high cycles.
  - S3: sort each of the 3 rows of the window into min/med/max.
  - S4: compute max of the three row-mins, med of the three row-meds, and min of the three row-maxes.
  - S5: result is the median of the three S4 values.
- **Output selection**
  - border = 1: img_y_out is the raw img_y_in of that pixel, delayed 5 clocks.
  - border = 0: img_y_out is the S5 median.
- **Geometry**
  - The window whose newest pixel is (r,c) is centred on (r-1,c-1). The output image is therefore shifted by 1 row and 1 column; this is accepted by design.
- **Arithmetic**
  - Unsigned 8-bit compares only; no width growth.
  - Ties resolve to either equal operand; the result value is identical either way.

## Timing
- Latency is 5 clocks, input to output, for data and all three syncs. Throughput is 1 pixel per clock with no back-pressure.
- Reset values: post_frame_vsync, post_frame_hsync and post_frame_de are 0; img_y_out is 0; col_cnt and row_cnt are 0.
- rst asserted mid-frame: all outputs are 0 from the next edge. After release, row_cnt is 0, so the next two lines take the raw path until row_cnt reaches 2. Stale line-buffer data is never selected because border covers rows 0–1.
- Lines shorter than IMG_WIDTH are handled normally. Pixels beyond IMG_WIDTH are passed through raw.
- A vsync rise during de-high clears row_cnt. The current line continues, with subsequent pixels flagged as border.
- A de falling edge and a vsync rising edge in the same cycle: the clear wins, and row_cnt = 0.
- Gaps of any length between lines have no effect on the window. The window restarts at col 0 of each line.

## Test plan
- **Reset:** hold rst for 3 clocks while driving de = 1, hsync = 1 and Y = 0xAA -> all outputs are 0 during rst and for 1 clock after. After release, post_frame_de rises exactly 5 clocks after the first de-high input.
- **Flat frame:** IMG_WIDTH = 8, 4 lines of 8 pixels with Y = 100 and 4 idle clocks between lines -> every de-high output is 100, with post_frame_de equal to pre_frame_de delayed 5.
- **Impulse:** the frame is all 50 except Y = 255 at (row 2, col 3) -> no output pixel equals 255; all outputs are 50.
- **Horizontal ramp:** Y = 10·col on every row, IMG_WIDTH = 8 ->
  - for row ≥ 2 and col ≥ 2, output = 10·(col-1);
  - for rows 0–1 and cols 0–1, output = 10·col.
- **Border passthrough and long line:** random Y, and a line of 10 pixels with IMG_WIDTH = 8 -> rows 0–1, cols 0–1 and pixels 8–9 equal their inputs delayed 5. The next line's median uses line-buffer columns 0–7 only.
- **Mid-frame events:**
  - a vsync pulse during row 3 -> the following line outputs raw Y;
  - an rst pulse mid-line -> outputs are 0 next clock, and the two lines after release are raw, then median resumes.
